// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory at the far end of the L1 dmem port.
// Reads complete after RD_LATENCY cycles. Writes are full-word and take effect
// on the clock edge where dmem_wr_en is high.
// Optional build macro DMEM_STATS_EN adds saturating read/write counters.
module dmem_responder #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_rd_en,
    input  logic              dmem_wr_en,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [DATA_W-1:0] data_to_dmem,
    output logic [DATA_W-1:0] data_from_dmem,
    output logic              dmem_rd_valid,
    output logic              dmem_busy
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: RD_LATENCY must be in 1..15");
    end

    localparam logic [3:0] LAT_LOAD = (RD_LATENCY >= 2) ? 4'(RD_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        lat_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_word;
    logic              rd_accept;

    assign dmem_busy = (state != IDLE);
    assign rd_accept = (state == IDLE) && dmem_rd_en;

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (dmem_wr_en) begin
            mem[dmem_address] <= data_to_dmem;
        end
    end

    // Response word: IDLE uses the live address (RD_LATENCY==1 enters RESP on
    // the accept edge); a write on the RESP-entry edge bypasses the array.
    always_comb begin
        rsp_addr = (state == IDLE) ? dmem_address : rd_addr;
        rsp_word = mem[rsp_addr];
        if (dmem_wr_en && (dmem_address == rsp_addr)) begin
            rsp_word = data_to_dmem;
        end
    end

    // Read-sequencing FSM with registered valid and data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            rd_addr        <= '0;
            data_from_dmem <= '0;
            dmem_rd_valid  <= 1'b0;
        end else begin
            dmem_rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmem_rd_en) begin
                        rd_addr <= dmem_address;
                        if (RD_LATENCY == 1) begin
                            state          <= RESP;
                            dmem_rd_valid  <= 1'b1;
                            data_from_dmem <= rsp_word;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state          <= RESP;
                        dmem_rd_valid  <= 1'b1;
                        data_from_dmem <= rsp_word;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating counters of accepted reads and write edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_accept && (rd_count != '1)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (dmem_wr_en && (wr_count != '1)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = rd_accept;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (RD_LATENCY 1, 2, 5) share the
// stimulus; a transaction-level model predicts every output each cycle.
// Stats checks are compiled when DMEM_STATS_EN is defined.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wd;

    logic [31:0] dout [3];
    logic        vld  [3];
    logic        bsy  [3];
`ifdef DMEM_STATS_EN
    logic [31:0] rdc  [3];
    logic [31:0] wrc  [3];
`endif

    int total;
    int bad;

    // Model state: a read is a countdown of LAT edges starting at the accept edge.
    int          lat_of [3];
    logic [31:0] mem_m  [1024];
    bit          m_idle [3];
    bit          m_resp [3];
    int          m_left [3];
    logic [9:0]  m_cap  [3];
    logic [31:0] m_data [3];
    logic [31:0] m_rdn  [3];
    logic [31:0] m_wrn;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wd;
        bit          v;
        bit          b;
        logic [31:0] d;
    } vec_t;
    vec_t tbl [14];

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .dmem_rd_en(rd), .dmem_wr_en(wr),
        .dmem_address(addr), .data_to_dmem(wd),
        .data_from_dmem(dout[0]), .dmem_rd_valid(vld[0]), .dmem_busy(bsy[0])
`ifdef DMEM_STATS_EN
        , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
    );

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .dmem_rd_en(rd), .dmem_wr_en(wr),
        .dmem_address(addr), .data_to_dmem(wd),
        .data_from_dmem(dout[1]), .dmem_rd_valid(vld[1]), .dmem_busy(bsy[1])
`ifdef DMEM_STATS_EN
        , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
    );

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(5)) u_l5 (
        .clk(clk), .reset(reset), .dmem_rd_en(rd), .dmem_wr_en(wr),
        .dmem_address(addr), .data_to_dmem(wd),
        .data_from_dmem(dout[2]), .dmem_rd_valid(vld[2]), .dmem_busy(bsy[2])
`ifdef DMEM_STATS_EN
        , .rd_count(rdc[2]), .wr_count(wrc[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_idle[i] = 1'b1;
            m_resp[i] = 1'b0;
            m_left[i] = 0;
            m_cap[i]  = '0;
            m_data[i] = '0;
            m_rdn[i]  = '0;
        end
        m_wrn = '0;
    endtask

    task automatic model_edge();
        if (wr) begin
            mem_m[addr] = wd;
            if (m_wrn != 32'hFFFF_FFFF) m_wrn = m_wrn + 1;
        end
        for (int i = 0; i < 3; i++) begin
            if (m_resp[i]) begin
                m_resp[i] = 1'b0;
                m_idle[i] = 1'b1;
            end else begin
                if (m_idle[i] && rd) begin
                    m_idle[i] = 1'b0;
                    m_cap[i]  = addr;
                    m_left[i] = lat_of[i];
                    if (m_rdn[i] != 32'hFFFF_FFFF) m_rdn[i] = m_rdn[i] + 1;
                end
                if (!m_idle[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_resp[i] = 1'b1;
                        m_data[i] = mem_m[m_cap[i]];
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk("valid", i, {31'd0, vld[i]}, {31'd0, m_resp[i]});
            chk("busy",  i, {31'd0, bsy[i]}, {31'd0, !m_idle[i]});
            chk("data",  i, dout[i], m_data[i]);
`ifdef DMEM_STATS_EN
            chk("rd_count", i, rdc[i], m_rdn[i]);
            chk("wr_count", i, wrc[i], m_wrn);
`endif
        end
    endtask

    task automatic drive(input bit r, input bit w, input logic [9:0] a, input logic [31:0] d);
        rd   = r;
        wr   = w;
        addr = a;
        wd   = d;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic chk_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", i, {31'd0, vld[i]}, 32'd0);
            chk("rst_busy",  i, {31'd0, bsy[i]}, 32'd0);
            chk("rst_data",  i, dout[i], 32'd0);
`ifdef DMEM_STATS_EN
            chk("rst_rd_count", i, rdc[i], 32'd0);
            chk("rst_wr_count", i, wrc[i], 32'd0);
`endif
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        lat_of[0] = 1;
        lat_of[1] = 2;
        lat_of[2] = 5;
        reset = 1'b0;
        drive(0, 0, '0, '0);

        // Directed vectors for the RD_LATENCY=2 instance.
        tbl[0]  = '{0, 1, 10'h005, 32'hDEAD_BEEF, 0, 0, 32'h0};
        tbl[1]  = '{1, 0, 10'h005, 32'h0,         0, 1, 32'h0};
        tbl[2]  = '{1, 0, 10'h005, 32'h0,         1, 1, 32'hDEAD_BEEF};
        tbl[3]  = '{0, 0, 10'h000, 32'h0,         0, 0, 32'hDEAD_BEEF};
        tbl[4]  = '{1, 0, 10'h020, 32'h0,         0, 1, 32'hDEAD_BEEF};
        tbl[5]  = '{1, 1, 10'h020, 32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D};
        tbl[6]  = '{0, 0, 10'h000, 32'h0,         0, 0, 32'hCAFE_F00D};
        tbl[7]  = '{1, 1, 10'h040, 32'h1234_5678, 0, 1, 32'hCAFE_F00D};
        tbl[8]  = '{1, 0, 10'h040, 32'h0,         1, 1, 32'h1234_5678};
        tbl[9]  = '{0, 0, 10'h000, 32'h0,         0, 0, 32'h1234_5678};
        tbl[10] = '{1, 0, 10'h020, 32'h0,         0, 1, 32'h1234_5678};
        tbl[11] = '{1, 0, 10'h050, 32'h0,         1, 1, 32'hCAFE_F00D};
        tbl[12] = '{0, 0, 10'h000, 32'h0,         0, 0, 32'hCAFE_F00D};
        tbl[13] = '{0, 0, 10'h000, 32'h0,         0, 0, 32'hCAFE_F00D};

        // Power-on reset.
        #2 reset = 1'b1;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fill every location so later reads have known contents.
        for (int a = 0; a < 1024; a++) begin
            drive(0, 1, 10'(a), 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0000);
            cycle();
        end
        drive(0, 0, '0, '0);
        cycle();

        for (int k = 0; k < 14; k++) begin
            drive(tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].wd);
            cycle();
            chk($sformatf("tbl%0d_valid", k), 1, {31'd0, vld[1]}, {31'd0, tbl[k].v});
            chk($sformatf("tbl%0d_busy", k),  1, {31'd0, bsy[1]}, {31'd0, tbl[k].b});
            chk($sformatf("tbl%0d_data", k),  1, dout[1], tbl[k].d);
        end
        drive(0, 0, '0, '0);
        repeat (6) cycle();

        // RD_LATENCY=1: held read at the top address returns every other cycle.
        drive(0, 1, 10'h3FF, 32'h1111_1111);
        cycle();
        drive(1, 0, 10'h3FF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("l1_held_valid", 0, {31'd0, vld[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("l1_held_busy",  0, {31'd0, bsy[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("l1_held_data",  0, dout[0], 32'h1111_1111);
        end
        drive(0, 0, '0, '0);
        repeat (6) cycle();

        // Reset while reads are in flight: outputs clear at once, no late pulse.
        drive(1, 0, 10'h100, 32'h0);
        cycle();
        drive(0, 0, '0, '0);
        cycle();
        chk("pre_rst_busy", 2, {31'd0, bsy[2]}, 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            for (int i = 0; i < 3; i++) begin
                chk("post_rst_valid", i, {31'd0, vld[i]}, 32'd0);
            end
        end

`ifdef DMEM_STATS_EN
        // Two writes and three single-pulse reads after reset.
        drive(0, 1, 10'h001, 32'hAAAA_0001);
        cycle();
        drive(0, 1, 10'h002, 32'hAAAA_0002);
        cycle();
        for (int r = 0; r < 3; r++) begin
            drive(1, 0, 10'(r), 32'h0);
            cycle();
            drive(0, 0, '0, '0);
            repeat (7) cycle();
        end
        for (int i = 0; i < 3; i++) begin
            chk("stats_rd", i, rdc[i], 32'd3);
            chk("stats_wr", i, wrc[i], 32'd2);
        end
`endif

        // Random traffic with a small address window to force collisions.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7)),
                  $urandom);
            cycle();
        end
        drive(0, 0, '0, '0);
        repeat (8) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
